program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter DataWidth, default 8, register/data width in bits.
REQ-002 SHALL have parameter NumOpCodeBits, default 5, opcode width in bits.
REQ-003 SHALL have parameter NumStatusBits, default 6, ALU status width in bits.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port run  input  1  1 = keep fetching; 0 = stop after the current instruction.
REQ-007 SHALL have port imem_req  output  1  one-cycle fetch request pulse.
REQ-008 SHALL have port imem_addr  output  8  fetch address, equal to pc.
REQ-009 SHALL have port imem_valid  input  1  instruction data valid.
REQ-010 SHALL have port imem_data  input  18  instruction {opcode[17:13], ra[12:11], rb[10:9], unused[8], param[7:0]}.
REQ-011 SHALL have port alu_opcode  output  5  opcode driven to the ALU.
REQ-012 SHALL have port alu_operand1  output  8  register ra contents.
REQ-013 SHALL have port alu_operand2  output  8  register rb contents.
REQ-014 SHALL have port alu_param  output  8  param field.
REQ-015 SHALL have port alu_result  input  8  combinational ALU result.
REQ-016 SHALL have port alu_status  input  6  combinational ALU status: bit0 carry, 1 underflow, 2 zero, 3 equal, 4 greater-than, 5 smaller-than.
REQ-017 SHALL have port pc  output  8  program counter.
REQ-018 SHALL have port status_q  output  6  latched status register.
REQ-019 SHALL have port illegal  output  1  one-cycle pulse on a reserved opcode.
REQ-020 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, WAIT, EXEC.
REQ-022 SHALL move IDLE->FETCH when run=1; otherwise stay in IDLE.
REQ-023 SHALL assert imem_req=1 with imem_addr=pc for exactly the one FETCH cycle, then enter WAIT.
REQ-024 SHALL stay in WAIT until imem_valid=1, latch imem_data into instr_q on that edge, then enter EXEC.
REQ-025 SHALL ignore imem_valid outside WAIT.
REQ-026 SHALL drive alu_opcode/param from instr_q and operands from regfile[ra]/regfile[rb] in EXEC; outside EXEC alu_opcode=5'b00000 and all other ALU outputs=0.
REQ-027 SHALL hold a 4 x 8-bit register file, with regfile[ra] and regfile[rb] read combinationally.
REQ-028 SHALL, at the end of EXEC for opcodes 00001-01000 (ADD..SHR), write alu_result to regfile[ra] and alu_status to status_q, and set pc=pc+1.
REQ-029 SHALL, for VAL (01001), write param to regfile[ra], leave status_q unchanged, and set pc=pc+1.
REQ-030 SHALL, for NOP (00000), write nothing and set pc=pc+1.
REQ-031 SHALL, for GOTO (10000), set pc=param.
REQ-032 SHALL, for IFZ/IFNZ/IFEQ/IFST/IFGT (10001..10101), set pc=param when status_q bit2 / !bit2 / bit3 / bit5 / bit4 respectively holds, else pc=pc+1.
REQ-033 SHALL leave status_q and the register file unchanged on all branch opcodes.
REQ-034 SHALL treat reserved opcodes (01010-01111, 10110-11111) as NOP and pulse illegal=1 in the cycle after EXEC.
REQ-035 SHALL compute pc+1 modulo 256 (8'hFF -> 8'h00).
REQ-036 SHALL, after EXEC, enter FETCH if run=1, else IDLE; a run deassertion mid-instruction SHALL NOT abort that instruction.
REQ-037 SHALL take a minimum of 3 cycles per instruction (FETCH, WAIT with imem_valid=1, EXEC).
REQ-038 SHALL evaluate branch conditions against status_q as latched before the current EXEC.

Reset
REQ-039 SHALL, while reset=1 at a clock edge in any state, go to IDLE and clear pc, status_q, instr_q and all registers to 0.
REQ-040 SHALL hold imem_req=0, imem_addr=0, illegal=0, busy=0 and all ALU outputs=0 immediately after reset.
REQ-041 SHALL drop any fetch in progress on reset, with the later imem_valid ignored.

Verification
REQ-042 SHALL verify: VAL r0,5; VAL r1,3; ADD r0,r1 -> r0=8, status_q=6'b010000, pc=3.
REQ-043 SHALL verify: VAL r0,7; VAL r1,7; SUB r0,r1; IFZ 0x40 -> status_q bit2=1 and bit3=1, pc=0x40.
REQ-044 SHALL verify: IFNZ 0x20 with status_q=6'b000100 -> pc=pc+1; GOTO 0xFF then NOP -> pc wraps to 0x00.
REQ-045 SHALL verify: imem_valid delayed 4 cycles -> FSM holds in WAIT, imem_req pulses only once, instruction executes correctly.
REQ-046 SHALL verify: opcode 5'b11010 -> illegal pulses exactly one cycle, registers and status_q unchanged, pc+1.
REQ-047 SHALL verify: reset asserted in WAIT followed by imem_valid -> IDLE, pc=0, all registers 0, no write occurs.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: fetch/wait/execute sequencer with a 4-entry register file driving an external ALU.
module program_sequencer #(
  parameter int DataWidth = 8,
  parameter int NumOpCodeBits = 5,
  parameter int NumStatusBits = 6
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   run,
  output logic                                   imem_req,
  output logic [DataWidth-1:0]                   imem_addr,
  input  logic                                   imem_valid,
  input  logic [NumOpCodeBits+DataWidth+4:0]     imem_data,
  output logic [NumOpCodeBits-1:0]               alu_opcode,
  output logic [DataWidth-1:0]                   alu_operand1,
  output logic [DataWidth-1:0]                   alu_operand2,
  output logic [DataWidth-1:0]                   alu_param,
  input  logic [DataWidth-1:0]                   alu_result,
  input  logic [NumStatusBits-1:0]               alu_status,
  output logic [DataWidth-1:0]                   pc,
  output logic [NumStatusBits-1:0]               status_q,
  output logic                                   illegal,
  output logic                                   busy
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EXEC} state_t;
  state_t state, state_nx;
  logic [NumOpCodeBits+DataWidth+4:0] instr_q;
  logic [DataWidth-1:0] regs [4];
  logic [NumOpCodeBits-1:0] op;
  logic [1:0] ra, rb;
  logic [DataWidth-1:0] param;
  logic is_alu, is_val, is_branch, reserved, taken, exec, unused;
  assign op = instr_q[NumOpCodeBits+DataWidth+4 -: NumOpCodeBits];
  assign ra = instr_q[DataWidth+4 -: 2];
  assign rb = instr_q[DataWidth+2 -: 2];
  assign param = instr_q[DataWidth-1:0];
  assign unused = instr_q[DataWidth];
  assign exec = state == EXEC;
  always_comb begin
    is_alu = op >= NumOpCodeBits'(1) && op <= NumOpCodeBits'(8);
    is_val = op == NumOpCodeBits'(9);
    is_branch = op >= NumOpCodeBits'(16) && op <= NumOpCodeBits'(21);
    reserved = !(op <= NumOpCodeBits'(9) || is_branch);
    // branches test the status latched by an earlier instruction, never the live ALU status
    taken = op == NumOpCodeBits'(16) ? 1'b1 :
            op == NumOpCodeBits'(17) ? status_q[2] :
            op == NumOpCodeBits'(18) ? !status_q[2] :
            op == NumOpCodeBits'(19) ? status_q[3] :
            op == NumOpCodeBits'(20) ? status_q[5] :
            op == NumOpCodeBits'(21) ? status_q[4] : 1'b0;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE  ? (run ? FETCH : IDLE) :
               state == FETCH ? WAIT :
               state == WAIT  ? (imem_valid ? EXEC : WAIT) :
               (run ? FETCH : IDLE);
  always_comb begin
    imem_req = state == FETCH;
    imem_addr = pc;
    busy = state != IDLE;
    alu_opcode = exec ? op : '0;
    alu_operand1 = exec ? regs[ra] : '0;
    alu_operand2 = exec ? regs[rb] : '0;
    alu_param = exec ? param : '0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      pc <= '0;
      status_q <= '0;
      instr_q <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      illegal <= exec && reserved;
      if (state == WAIT && imem_valid) instr_q <= imem_data;
      if (exec) begin
        pc <= is_branch && taken ? param : pc + DataWidth'(1);
        if (is_alu) begin
          regs[ra] <= alu_result;
          status_q <= alu_status;
        end
        if (is_val) regs[ra] <= param;
      end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed table plus randomized instruction stream checked against an architectural model.
module tb_program_sequencer;
  logic clock = 1'b0, reset, run, imem_req, imem_valid, illegal, busy;
  logic [7:0] imem_addr, alu_operand1, alu_operand2, alu_param, alu_result, pc;
  logic [17:0] imem_data;
  logic [4:0] alu_opcode;
  logic [5:0] alu_status, status_q;
  int n_checks = 0, n_fail = 0;
  logic [7:0] mregs [4];
  logic [7:0] mpc;
  logic [5:0] mst;
  typedef struct {
    logic [17:0] d;
    int dly;
    logic [7:0] epc;
    logic [5:0] est;
    logic eill;
  } vec_t;
  vec_t tbl [18];

  program_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .alu_opcode(alu_opcode),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_param(alu_param),
    .alu_result(alu_result), .alu_status(alu_status), .pc(pc), .status_q(status_q),
    .illegal(illegal), .busy(busy)
  );

  always #5 clock = ~clock;

  // ALU: status = {smaller, greater, equal, zero, underflow, carry}
  function automatic logic [13:0] alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic [5:0] s;
    w = 9'd0;
    r = 8'd0;
    s = 6'd0;
    case (op)
      5'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; s = {a < b, a > b, a == b, r == 0, 1'b0, w[8]}; end
      5'd2: begin r = a - b; s = {a < b, a > b, a == b, r == 0, a < b, 1'b0}; end
      5'd3: begin r = a & b; s = {3'b0, r == 0, 2'b0}; end
      5'd4: begin r = a | b; s = {3'b0, r == 0, 2'b0}; end
      5'd5: begin r = a ^ b; s = {3'b0, r == 0, 2'b0}; end
      5'd6: begin r = ~a; s = {3'b0, r == 0, 2'b0}; end
      5'd7: begin r = {a[6:0], 1'b0}; s = {3'b0, r == 0, 1'b0, a[7]}; end
      5'd8: begin r = {1'b0, a[7:1]}; s = {3'b0, r == 0, 1'b0, a[0]}; end
      default: ;
    endcase
    return {s, r};
  endfunction

  always_comb {alu_status, alu_result} = alu(alu_opcode, alu_operand1, alu_operand2);

  function automatic logic [17:0] enc(input int op, input int ra, input int rb, input int p);
    return {op[4:0], ra[1:0], rb[1:0], 1'b0, p[7:0]};
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    mpc = 8'd0;
    mst = 6'd0;
  endtask

  // Drives one fetch/wait/exec handshake and checks it against the architectural model.
  task automatic do_instr(input logic [17:0] d, input int dly, input bit stop, input bit noise);
    int k;
    logic [4:0] op;
    logic [1:0] ra, rb;
    logic [7:0] p, r;
    logic [5:0] s;
    logic ill, tk;
    op = d[17:13];
    ra = d[12:11];
    rb = d[10:9];
    p = d[7:0];
    k = 0;
    while (!imem_req && k < 20) begin
      step;
      k++;
    end
    chk("fetch_req", imem_req, 1);
    if (!imem_req) return;
    chk("fetch_addr", imem_addr, mpc);
    chk("fetch_busy", busy, 1);
    if (noise) begin
      imem_valid = 1'b1;
      imem_data = 18'($urandom);
    end
    step;
    imem_valid = 1'b0;
    chk("wait_illegal", illegal, 0);
    if (stop) run = 1'b0;
    repeat (dly) begin
      chk("wait_req", imem_req, 0);
      chk("wait_busy", busy, 1);
      step;
    end
    imem_valid = 1'b1;
    imem_data = d;
    step;
    imem_valid = noise;
    imem_data = 18'($urandom);
    chk("exec_opcode", alu_opcode, op);
    chk("exec_op1", alu_operand1, mregs[ra]);
    chk("exec_op2", alu_operand2, mregs[rb]);
    chk("exec_param", alu_param, p);
    chk("exec_req", imem_req, 0);
    ill = 1'b0;
    if (op >= 1 && op <= 8) begin
      {s, r} = alu(op, mregs[ra], mregs[rb]);
      mregs[ra] = r;
      mst = s;
      mpc = mpc + 8'd1;
    end else if (op == 9) begin
      mregs[ra] = p;
      mpc = mpc + 8'd1;
    end else if (op >= 16 && op <= 21) begin
      tk = op == 16 || (op == 17 && mst[2]) || (op == 18 && !mst[2]) ||
           (op == 19 && mst[3]) || (op == 20 && mst[5]) || (op == 21 && mst[4]);
      mpc = tk ? p : mpc + 8'd1;
    end else begin
      ill = op != 0;
      mpc = mpc + 8'd1;
    end
    step;
    imem_valid = 1'b0;
    chk("post_pc", pc, mpc);
    chk("post_status", status_q, mst);
    chk("post_illegal", illegal, ill);
    if (stop) begin
      chk("stop_busy", busy, 0);
      chk("stop_req", imem_req, 0);
      step;
      chk("idle_busy", busy, 0);
      chk("idle_illegal", illegal, 0);
      run = 1'b1;
    end
  endtask

  initial begin
    tbl[0]  = '{enc(9, 0, 0, 5),      0, 8'h01, 6'b000000, 1'b0};
    tbl[1]  = '{enc(9, 1, 0, 3),      1, 8'h02, 6'b000000, 1'b0};
    tbl[2]  = '{enc(1, 0, 1, 0),      4, 8'h03, 6'b010000, 1'b0};
    tbl[3]  = '{enc(9, 0, 0, 7),      0, 8'h04, 6'b010000, 1'b0};
    tbl[4]  = '{enc(9, 1, 0, 7),      0, 8'h05, 6'b010000, 1'b0};
    tbl[5]  = '{enc(2, 0, 1, 0),      2, 8'h06, 6'b001100, 1'b0};
    tbl[6]  = '{enc(17, 0, 0, 'h40),  0, 8'h40, 6'b001100, 1'b0};
    tbl[7]  = '{enc(9, 2, 0, 'h0F),   0, 8'h41, 6'b001100, 1'b0};
    tbl[8]  = '{enc(9, 3, 0, 'hF0),   0, 8'h42, 6'b001100, 1'b0};
    tbl[9]  = '{enc(3, 2, 3, 0),      0, 8'h43, 6'b000100, 1'b0};
    tbl[10] = '{enc(18, 0, 0, 'h20),  0, 8'h44, 6'b000100, 1'b0};
    tbl[11] = '{enc(16, 0, 0, 'hFF),  0, 8'hFF, 6'b000100, 1'b0};
    tbl[12] = '{enc(0, 0, 0, 0),      0, 8'h00, 6'b000100, 1'b0};
    tbl[13] = '{enc(26, 1, 2, 'h33),  0, 8'h01, 6'b000100, 1'b1};
    tbl[14] = '{enc(19, 2, 3, 'h10),  0, 8'h02, 6'b000100, 1'b0};
    tbl[15] = '{enc(2, 1, 0, 0),      0, 8'h03, 6'b010000, 1'b0};
    tbl[16] = '{enc(21, 0, 0, 'h80),  0, 8'h80, 6'b010000, 1'b0};
    tbl[17] = '{enc(20, 0, 0, 'h90),  0, 8'h81, 6'b010000, 1'b0};
    reset = 1'b1;
    run = 1'b0;
    imem_valid = 1'b0;
    imem_data = '0;
    repeat (3) step;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", pc, 0);
    chk("rst_status", status_q, 0);
    chk("rst_alu", {alu_opcode, alu_operand1, alu_operand2, alu_param}, 0);
    model_reset();
    run = 1'b1;
    foreach (tbl[i]) begin
      do_instr(tbl[i].d, tbl[i].dly, 1'b0, 1'b0);
      chk("tbl_pc", pc, tbl[i].epc);
      chk("tbl_status", status_q, tbl[i].est);
      chk("tbl_illegal", illegal, tbl[i].eill);
    end
    do_instr(enc(9, 3, 0, 'h21), 1, 1'b1, 1'b0);
    // reset while waiting for instruction data; the late data must be ignored
    k_wait: begin
      int k;
      k = 0;
      while (!imem_req && k < 20) begin
        step;
        k++;
      end
      chk("rw_fetch", imem_req, 1);
    end
    step;
    reset = 1'b1;
    run = 1'b0;
    step;
    reset = 1'b0;
    imem_valid = 1'b1;
    imem_data = enc(9, 0, 0, 'h55);
    step;
    step;
    imem_valid = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_pc", pc, 0);
    chk("rw_status", status_q, 0);
    chk("rw_req", imem_req, 0);
    chk("rw_alu", {alu_opcode, alu_operand1, alu_operand2, alu_param}, 0);
    model_reset();
    run = 1'b1;
    do_instr(enc(1, 0, 1, 0), 0, 1'b0, 1'b0);
    do_instr(enc(4, 2, 3, 0), 0, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++)
      do_instr(enc($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)),
               $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
